// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode stage with a one-entry skid buffer.
//
// The incoming word is sliced and its immediate extended on the input side;
// the resulting bundle {fields, imm_ext, pc} is stored in a main register (M)
// whose contents drive every output. A second register (S) catches the word
// accepted in the cycle downstream stalls, so in_ready can come straight from
// a flop with no combinational path from out_ready.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_instr, in_pc, sext sampled on accept
//   flush               discard held words and any word accepted this cycle
//   out_valid/out_ready downstream handshake
//   opcode, fcode, rs, rt, imm, imm_ext, jaddr, out_pc   decoded bundle (from M)
//   dec_count           wrapping count of bundles handed downstream
module decode_stage #(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 2,
  parameter int FC_W    = 4,
  parameter int RA_W    = 5,
  parameter int IMM_W   = 16,
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INSTR_W-1:0]          in_instr,
  input  logic [PC_W-1:0]             in_pc,
  input  logic                        sext,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OPC_W-1:0]            opcode,
  output logic [FC_W-1:0]             fcode,
  output logic [RA_W-1:0]             rs,
  output logic [RA_W-1:0]             rt,
  output logic [IMM_W-1:0]            imm,
  output logic [DATA_W-1:0]           imm_ext,
  output logic [INSTR_W-OPC_W-FC_W-1:0] jaddr,
  output logic [PC_W-1:0]             out_pc,
  output logic [CNT_W-1:0]            dec_count
);

  localparam int JW   = INSTR_W - OPC_W - FC_W;
  // Bundle layout, LSB first: pc, jaddr, imm_ext, imm, rt, rs, fcode, opcode
  localparam int P_JA = PC_W;
  localparam int P_IX = P_JA + JW;
  localparam int P_IM = P_IX + DATA_W;
  localparam int P_RT = P_IM + IMM_W;
  localparam int P_RS = P_RT + RA_W;
  localparam int P_FC = P_RS + RA_W;
  localparam int P_OP = P_FC + FC_W;
  localparam int BW   = P_OP + OPC_W;

  logic [IMM_W-1:0]  in_imm;
  logic [DATA_W-1:0] in_ext;
  logic [BW-1:0]     in_bundle;

  logic [BW-1:0]     m_data_q, m_data_d, s_data_q, s_data_d;
  logic              m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, handoff;

  // Extension done bit-wise so DATA_W == IMM_W needs no zero-width replication
  always_comb begin
    in_imm = in_instr[IMM_W-1:0];
    in_ext = '0;
    in_ext[IMM_W-1:0] = in_imm;
    for (int i = IMM_W; i < DATA_W; i++) in_ext[i] = sext & in_imm[IMM_W-1];
  end

  assign in_bundle = {in_instr[INSTR_W-1 -: OPC_W],
                      in_instr[INSTR_W-OPC_W-1 -: FC_W],
                      in_instr[INSTR_W-OPC_W-FC_W-1 -: RA_W],
                      in_instr[INSTR_W-OPC_W-FC_W-RA_W-1 -: RA_W],
                      in_imm, in_ext, in_instr[JW-1:0], in_pc};

  assign accept  = in_valid && rdy_q;
  assign handoff = m_valid_q && out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    cnt_d     = cnt_q;
    if (handoff) cnt_d = cnt_q + CNT_W'(1);

    if (handoff) begin
      // S full implies in_ready was low, so no accept can collide with the refill
      if (s_valid_q) begin
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_data_d  = in_bundle;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!m_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = in_bundle;
      end else begin
        s_valid_d = 1'b1;
        s_data_d  = in_bundle;
      end
    end

    // Flush drops everything, including a word accepted this cycle;
    // the handoff count above is left intact.
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end

    rdy_d = !s_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_data_q  <= '0;
      rdy_q     <= 1'b1;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
      rdy_q     <= rdy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = m_valid_q;
  assign opcode    = m_data_q[P_OP +: OPC_W];
  assign fcode     = m_data_q[P_FC +: FC_W];
  assign rs        = m_data_q[P_RS +: RA_W];
  assign rt        = m_data_q[P_RT +: RA_W];
  assign imm       = m_data_q[P_IM +: IMM_W];
  assign imm_ext   = m_data_q[P_IX +: DATA_W];
  assign jaddr     = m_data_q[P_JA +: JW];
  assign out_pc    = m_data_q[PC_W-1:0];
  assign dec_count = cnt_q;

endmodule
